bram_frame_reader: RTL

Sequential read-side master for the single-port-read `bram` cell-state memory. On a `start` pulse it scans addresses 0..DEPTH-1 through the memory's 1-cycle-latency read port and presents each word on a valid/ready stream with a last-word marker, absorbing read latency and downstream backpressure in a 2-entry buffer. It sits between the cell-state memory and consumers such as the display scanout and the next-generation engine.

---
 rtl/bram_reader_pkg.sv | 13 +
 rtl/stream_fifo2.sv | 51 +++++
 rtl/bram_frame_reader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/bram_reader_pkg.sv
// Shared types for the bram frame reader: FSM state encoding
// and the depth of the output skid buffer.
package bram_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO of {last, data} words for the frame reader.
// Ports: clk, reset (async high), push/push_data, pop, flush,
// head (oldest entry), count (0..2).
module stream_fifo2
  import bram_reader_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic             wr_q;
  logic             rd_q;
  logic [1:0]       cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/bram_frame_reader.sv
// Scans a 1-cycle-latency bram 0..DEPTH-1 onto a valid/ready
// stream with a last marker, buffering up to two words.
// Ports: clk, reset (async high), start, stop, busy, done,
// mem_read_addr/enable/data (bram), m_data/valid/ready/last.
// Define BRAM_FRAME_READER_LOOP_EN for continuous frames.
module bram_frame_reader
  import bram_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 200,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  output logic                  mem_read_enable,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
    ADDR_WIDTH'(DEPTH - 1);

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  infl_q;
  logic                  infl_last_q;
  logic                  issue;
  logic                  flush;
  logic                  pop;
  logic                  push;
  logic [1:0]            count;
  logic [2:0]            occ;
  logic [DATA_WIDTH:0]   head;
  logic                  head_last;

  assign pop       = m_valid & m_ready;
  assign push      = infl_q & ~flush;
  assign head_last = head[DATA_WIDTH];

  // Occupancy the buffer would reach if nothing new were issued;
  // an issue is allowed only while it leaves room for the word.
  assign occ = 3'(count) + 3'(infl_q) - 3'(pop);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    flush   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (stop) begin
          flush   = 1'b1;
          state_d = IDLE;
        end else if (occ < 3'(BUF_DEPTH)) begin
          issue = 1'b1;
          if (cnt_q == LAST_ADDR) begin
`ifdef BRAM_FRAME_READER_LOOP_EN
            cnt_d = '0;
`else
            state_d = DRAIN;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (stop) begin
          flush   = 1'b1;
          state_d = IDLE;
        end else if (pop && head_last) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      infl_q      <= issue;
      infl_last_q <= issue && (cnt_q == LAST_ADDR);
      if (issue) begin
        addr_q <= cnt_q;
      end
    end
  end

  stream_fifo2 #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data({infl_last_q, mem_read_data}),
    .pop      (pop),
    .flush    (flush),
    .head     (head),
    .count    (count)
  );

  assign busy            = (state_q != IDLE);
  assign mem_read_enable = issue;
  assign mem_read_addr   = issue ? cnt_q : addr_q;
  assign m_valid         = (count != 2'd0);
  assign m_data          = m_valid ? head[DATA_WIDTH-1:0] : '0;
  assign m_last          = m_valid & head_last;

endmodule
